// File: rtl/regfile_dumper.sv
// Register-file dumper: walks an address range (with wrap) and streams each entry out over valid/ready.
// Optional macro DUMP_PARITY_EN adds an even-parity output captured alongside out_data.
module regfile_dumper #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] first_addr,
    input  logic [AW-1:0] last_addr,
    output logic [AW-1:0] rf_addr,
    input  logic [DW-1:0] rf_data,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_idx,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
`ifdef DUMP_PARITY_EN
    ,
    output logic          out_parity
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] last_q, last_d;
    logic [DW-1:0] data_q, data_d;
    logic [AW-1:0] oidx_q, oidx_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
`ifdef DUMP_PARITY_EN
    logic          parity_q, parity_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            last_q   <= '0;
            data_q   <= '0;
            oidx_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef DUMP_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            data_q   <= data_d;
            oidx_q   <= oidx_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef DUMP_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state and output logic; abort takes priority over the handshake.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        last_d   = last_q;
        data_d   = data_q;
        oidx_d   = oidx_q;
        valid_d  = valid_q;
`ifdef DUMP_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    idx_d   = first_addr;
                    last_d  = last_addr;
                end
            end
            FETCH: begin
                if (abort) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else begin
                    data_d   = rf_data;
                    oidx_d   = idx_q;
                    valid_d  = 1'b1;
`ifdef DUMP_PARITY_EN
                    parity_d = ^rf_data;
`endif
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else if (out_ready) begin
                    valid_d = 1'b0;
                    if (idx_q == last_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d == FETCH) || (state_d == SEND);
        done_d = (state_d == DONE);
    end

    assign rf_addr    = idx_q;
    assign out_data   = data_q;
    assign out_idx    = oidx_q;
    assign out_valid  = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef DUMP_PARITY_EN
    assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_regfile_dumper.sv
// Randomized bench for regfile_dumper against a queue-based model of the expected beat stream.
module tb_regfile_dumper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [2:0] first_addr;
    logic [2:0] last_addr;
    logic [2:0] rf_addr;
    logic [7:0] rf_data;
    logic [7:0] out_data;
    logic [2:0] out_idx;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;
`ifdef DUMP_PARITY_EN
    logic       out_parity;
`endif

    logic [7:0] regs [8];

    regfile_dumper #(.DW(8), .AW(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
`ifdef DUMP_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    always #5 clk = ~clk;
    assign rf_data = regs[rf_addr];

    int n_vec  = 0;
    int n_fail = 0;

    // Expected beat stream of the dump in flight
    int         q_idx [$];
    logic [7:0] q_dat [$];
    bit         done_pending = 0;
    bit         done_seen    = 0;
    bit         aborted      = 0;
    bit         hold         = 0;
    bit         spacing_on   = 0;
    logic [7:0] prev_data;
    logic [2:0] prev_idx;
    int         cyc = 0;
    int         last_beat_cyc = 0;
    int         beat_n = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Observe outputs at the falling edge, then return just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        chk("busy", 32'(busy), 32'(q_idx.size() != 0));
        chk("done", 32'(done), 32'(done_pending));
        done_pending = 0;
        if (done) done_seen = 1;
        if (hold) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(prev_data));
            chk("hold_idx", 32'(out_idx), 32'(prev_idx));
        end
        hold = 0;
        if (out_valid && q_idx.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
`ifdef DUMP_PARITY_EN
        if (out_valid) chk("parity", 32'(out_parity), 32'(^out_data));
`endif
        if (abort && busy) begin
            q_idx.delete();
            q_dat.delete();
            aborted = 1;
        end else if (out_valid && out_ready && q_idx.size() != 0) begin
            chk("beat_idx", 32'(out_idx), 32'(q_idx[0]));
            chk("beat_data", 32'(out_data), 32'(q_dat[0]));
            void'(q_idx.pop_front());
            void'(q_dat.pop_front());
            if (spacing_on && beat_n > 0) chk("beat_spacing", 32'(cyc - last_beat_cyc), 32'd2);
            last_beat_cyc = cyc;
            beat_n++;
            if (q_idx.size() == 0) done_pending = 1;
        end else if (out_valid) begin
            hold      = 1;
            prev_data = out_data;
            prev_idx  = out_idx;
        end
        @(posedge clk);
        #1;
    endtask

    // rmode: 0 random ready with random abort/start noise, 1 always ready, 2 stall 5 cycles on idx 2
    task automatic run_dump(input int f, input int l, input int rmode);
        int n;
        int stall;
        first_addr = 3'(f);
        last_addr  = 3'(l);
        start      = 1'b1;
        tick();
        start = 1'b0;
        n = ((l - f) & 7) + 1;
        for (int k = 0; k < n; k++) begin
            q_idx.push_back((f + k) % 8);
            q_dat.push_back(regs[(f + k) % 8]);
        end
        done_seen  = 0;
        aborted    = 0;
        beat_n     = 0;
        stall      = 0;
        spacing_on = (rmode == 1);
        for (int k = 0; k < 200; k++) begin
            if (done_seen || (aborted && !busy)) break;
            abort = 1'b0;
            start = 1'b0;
            case (rmode)
                1:       out_ready = 1'b1;
                2: begin
                    if (out_valid && out_idx == 3'd2 && stall < 5) begin
                        out_ready = 1'b0;
                        stall++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: begin
                    out_ready = ($urandom_range(0, 9) < 7);
                    if ($urandom_range(0, 39) == 0) abort = 1'b1;
                    if ((busy || done) && !abort && $urandom_range(0, 7) == 0) begin
                        start      = 1'b1;
                        first_addr = 3'($urandom_range(0, 7));
                        last_addr  = 3'($urandom_range(0, 7));
                    end
                end
            endcase
            tick();
        end
        abort = 1'b0;
        start = 1'b0;
        if (!(done_seen || aborted)) chk("timeout", 32'd0, 32'd1);
        if (!aborted) chk("beat_count", 32'(beat_n), 32'(n));
        if (rmode == 2) chk("stall_cycles", 32'(stall), 32'd5);
        spacing_on = 0;
        tick();
        tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        out_ready  = 1'b1;
        for (int i = 0; i < 8; i++) regs[i] = 8'(i * 8'h11);
        #4;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rf_addr", 32'(rf_addr), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        run_dump(0, 7, 1);
        run_dump(6, 1, 1);
        run_dump(3, 3, 1);
        run_dump(0, 7, 2);

        // Abort coinciding with the handshake of beat idx 4, then a clean restart
        first_addr = 3'd0;
        last_addr  = 3'd7;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            q_idx.push_back(k);
            q_dat.push_back(regs[k]);
        end
        done_seen = 0;
        aborted   = 0;
        for (int k = 0; k < 50; k++) begin
            if (out_valid && out_idx == 3'd4) break;
            tick();
        end
        chk("abort_reach_idx4", 32'(out_idx), 32'd4);
        abort     = 1'b1;
        out_ready = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        for (int k = 0; k < 4; k++) tick();
        chk("abort_no_done", 32'(done_seen), 32'd0);
        run_dump(2, 5, 1);

        // Reset asserted while a beat is waiting in SEND
        for (int i = 0; i < 8; i++) regs[i] = 8'(i * 8'h11);
        regs[5] = 8'h07;
        first_addr = 3'd3;
        last_addr  = 3'd6;
        start      = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            q_idx.push_back(3 + k);
            q_dat.push_back(regs[3 + k]);
        end
        tick();
        tick();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        chk("arst_idx", 32'(out_idx), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rf_addr", 32'(rf_addr), 32'd0);
`ifdef DUMP_PARITY_EN
        chk("arst_parity", 32'(out_parity), 32'd0);
`endif
        q_idx.delete();
        q_dat.delete();
        hold         = 0;
        done_pending = 0;
        out_ready    = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        run_dump(5, 5, 1);
        run_dump(3, 6, 1);

        // Randomized dumps with random register contents
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);
            run_dump(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_dumper.md
REGFILE_DUMPER -- requirements
Module: regfile_dumper

Interface
REQ-001 SHALL have parameter DW, default 8, data width of one register entry.
REQ-002 SHALL have parameter AW, default 3, register address width (2**AW entries).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, dump request pulse; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1, terminates the dump in progress.
REQ-007 SHALL have port first_addr, input, AW, first register to read, sampled with start.
REQ-008 SHALL have port last_addr, input, AW, last register to read inclusive, sampled with start.
REQ-009 SHALL have port rf_addr, output, AW, read address driven to the register-file read port.
REQ-010 SHALL have port rf_data, input, DW, combinational read data returned for rf_addr.
REQ-011 SHALL have port out_data, output, DW, captured register value.
REQ-012 SHALL have port out_idx, output, AW, register index of out_data.
REQ-013 SHALL have port out_valid, output, 1, out_data/out_idx valid.
REQ-014 SHALL have port out_ready, input, 1, consumer accepts the beat when high with out_valid.
REQ-015 SHALL have ports busy and done, output, 1 each, dump active, and one-cycle completion pulse.

Function
REQ-016 SHALL implement the states IDLE, FETCH, SEND and DONE.
REQ-017 SHALL move IDLE->FETCH on start=1, latching first_addr and last_addr and loading the index with first_addr.
REQ-018 SHALL drive rf_addr from the index register at all times.
REQ-019 SHALL, in FETCH, capture rf_data into out_data, capture the index into out_idx, assert out_valid and go to SEND on the next edge (one cycle from rf_addr to valid).
REQ-020 SHALL hold out_valid, out_data and out_idx stable in SEND until out_valid&&out_ready on a rising edge.
REQ-021 SHALL, on handshake: go to DONE if index==last; else increment the index modulo 2**AW and go to FETCH.
REQ-022 SHALL read (last_addr-first_addr) mod 2**AW + 1 entries, wrapping 7->0 when last_addr<first_addr; first_addr==last_addr reads exactly one entry.
REQ-023 SHALL pulse done=1 for exactly one cycle in DONE, then go to IDLE; out_valid=0 in DONE.
REQ-024 SHALL assert busy in FETCH and SEND only.
REQ-025 SHALL ignore start outside IDLE.
REQ-026 SHALL, on abort=1 in FETCH or SEND, go to IDLE on that edge with out_valid=0 and no done pulse; abort wins over a simultaneous handshake; abort in IDLE/DONE has no effect.
REQ-027 SHALL accept out_ready high before out_valid without any effect.

Reset
REQ-028 SHALL, while rst_n=0, immediately force state=IDLE, index=0, rf_addr=0, out_data=0, out_idx=0, out_valid=0, busy=0, done=0 and parity=0.
REQ-029 SHALL, on reset assertion mid-dump, discard the transfer; the first dump after release starts cleanly from start.

Configuration
REQ-030 SHALL, with macro DUMP_PARITY_EN defined, add output out_parity (1 bit) = XOR of out_data (even parity), captured in FETCH alongside out_data.
REQ-031 SHALL, without DUMP_PARITY_EN, omit the out_parity port and logic, with identical other behaviour.

Verification
REQ-032 Regs r0..r7 = 00,11,..,77; start, first=0, last=7, out_ready=1 -> 8 beats idx 0..7, data 00..77, one beat every 2 cycles, done pulse once.
REQ-033 first=6, last=1 -> beats idx 6,7,0,1 in order, then done.
REQ-034 first=last=3 -> exactly one beat idx 3, data 33, then done.
REQ-035 out_ready low 5 cycles during beat idx 2 -> out_valid/out_data held stable, no skip, no duplicate.
REQ-036 abort with handshake on beat idx 4 -> out_valid=0 next cycle, busy=0, no done; a new start then runs normally.
REQ-037 rst_n low mid-SEND -> all outputs 0 asynchronously; DUMP_PARITY_EN build: data 0x07 -> out_parity=1.
